// File: rtl/ahb3lite_mem_slave_if.sv
// AHB3-Lite bus bundle between one master (or the interconnect) and the
// on-chip SRAM slave.
//   master modport : drives HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/
//                    HWDATA/HREADY; receives HRDATA/HREADYOUT/HRESP
//   slave modport  : the mirror image
// HCLK and HRESETn are not part of the bundle; they are plain module ports.
interface ahb3lite_mem_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite slave in front of a word-organised SRAM (MEM_WORDS x 32 bit),
// addressed by a byte address. Legal transfers complete with zero wait states
// and OKAY; illegal transfers (bad size, misaligned, out of range) get a
// two-cycle ERROR and never touch memory.
//
// Ports:
//   HCLK    in  clock, rising edge
//   HRESETn in  synchronous reset, ACTIVE HIGH despite the name
//   bus     AHB slave modport (see ahb3lite_mem_slave_if)
//
// Optional feature: define AHB_WAIT_STATE_EN to insert one wait state in
// every legal read data phase. Writes and ERROR responses are unaffected.
//
// state  | meaning
// S_DATA | normal data phase (idle, legal write or legal read), HREADYOUT=1
// S_WAIT | read wait state (AHB_WAIT_STATE_EN only), HREADYOUT=0
// S_ERR1 | first ERROR cycle, HREADYOUT=0, HRESP=1
// S_ERR2 | second ERROR cycle, HREADYOUT=1, HRESP=1
module ahb3lite_mem_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 16384
) (
  input logic                 HCLK,
  input logic                 HRESETn,
  ahb3lite_mem_slave_if.slave bus
);

  localparam int          IDX_W       = ADDR_WIDTH - 2;
  localparam logic [31:0] MEM_WORDS_U = MEM_WORDS;

  typedef enum logic [1:0] {S_DATA, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                state, state_nxt;
  logic                  dp_valid, dp_valid_nxt;
  logic                  dp_write, dp_write_nxt;
  logic [ADDR_WIDTH-1:0] dp_addr, dp_addr_nxt;
  logic [2:0]            dp_size, dp_size_nxt;

  logic                  rst;
  logic                  bus_free;
  logic                  accept;
  logic                  illegal;
  logic [3:0]            be;
  logic                  wr_en;
  logic                  rd_phase;
  logic [IDX_W-1:0]      dp_idx;
  logic                  unused;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  assign rst    = HRESETn;
  assign unused = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};
  assign dp_idx = dp_addr[ADDR_WIDTH-1:2];

  // A new address phase can only complete in a cycle where this slave is
  // itself driving HREADYOUT high.
  assign bus_free = (state == S_DATA) || (state == S_ERR2);
  assign accept   = bus_free & bus.HSEL & bus.HREADY & bus.HTRANS[1];

  always_comb begin
    illegal = 1'b0;
    case (bus.HSIZE)
      3'd0:    illegal = 1'b0;
      3'd1:    illegal = bus.HADDR[0];
      3'd2:    illegal = |bus.HADDR[1:0];
      default: illegal = 1'b1;
    endcase
    if ({{(32-IDX_W){1'b0}}, bus.HADDR[ADDR_WIDTH-1:2]} >= MEM_WORDS_U)
      illegal = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (rst) begin
      state    <= S_DATA;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= '0;
    end else begin
      state    <= state_nxt;
      dp_valid <= dp_valid_nxt;
      dp_write <= dp_write_nxt;
      dp_addr  <= dp_addr_nxt;
      dp_size  <= dp_size_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    dp_valid_nxt = dp_valid;
    dp_write_nxt = dp_write;
    dp_addr_nxt  = dp_addr;
    dp_size_nxt  = dp_size;
    case (state)
      // Registered address is held so the following S_DATA cycle can
      // return the read data.
      S_WAIT: state_nxt = S_DATA;
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        // Current data phase completes at this edge.
        state_nxt    = S_DATA;
        dp_valid_nxt = 1'b0;
        if (accept) begin
          dp_write_nxt = bus.HWRITE;
          dp_addr_nxt  = bus.HADDR;
          dp_size_nxt  = bus.HSIZE;
          if (illegal) begin
            state_nxt = S_ERR1;
          end else begin
            dp_valid_nxt = 1'b1;
`ifdef AHB_WAIT_STATE_EN
            if (!bus.HWRITE) state_nxt = S_WAIT;
`endif
          end
        end
      end
    endcase
  end

  always_comb begin
    case (dp_size)
      3'd0:    be = 4'b0001 << dp_addr[1:0];
      3'd1:    be = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Gated by reset so a write caught mid data phase is dropped.
  assign wr_en    = (state == S_DATA) & dp_valid & dp_write & ~rst;
  assign rd_phase = (state == S_DATA) & dp_valid & ~dp_write;

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[dp_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = (state == S_DATA) || (state == S_ERR2);
  assign bus.HRESP     = (state == S_ERR1) || (state == S_ERR2);
  assign bus.HRDATA    = rd_phase ? mem[dp_idx] : '0;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
module tb_ahb3lite_mem_slave;

  localparam int MEM_WORDS = 16384;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
  } resp_t;

  typedef struct packed {
    bit        sel;
    bit [1:0]  trans;
    bit        write;
    bit [2:0]  size;
    bit [15:0] addr;
    bit [31:0] wdata;
  } xfer_t;

  logic HCLK;
  logic HRESETn;

  ahb3lite_mem_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  ahb3lite_mem_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_WORDS(MEM_WORDS)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  assign bus.HREADY = bus.HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int    n_assert = 0;
  int    n_fail   = 0;
  xfer_t seq_q[$];
  resp_t exp_q[$];
  resp_t obs_q[$];
  bit [31:0] mem_m [int];
  bit    wait_en;

  initial begin
`ifdef AHB_WAIT_STATE_EN
    wait_en = 1'b1;
`else
    wait_en = 1'b0;
`endif
  end

  function automatic void add(bit sel, bit [1:0] trans, bit write, bit [2:0] size,
                              bit [15:0] addr, bit [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.write = write; x.size = size;
    x.addr = addr; x.wdata = wdata;
    seq_q.push_back(x);
  endfunction

  // 0 = no access, 1 = illegal, 2 = legal write, 3 = legal read
  function automatic int kind_of(xfer_t x);
    int nbytes;
    if (!x.sel || !x.trans[1]) return 0;
    if (x.size > 2) return 1;
    nbytes = 1 << x.size;
    if ((int'(x.addr) % nbytes) != 0) return 1;
    if ((int'(x.addr) / 4) >= MEM_WORDS) return 1;
    return x.write ? 2 : 3;
  endfunction

  // Reference: per-cycle expected responses for the data phases of seq_q,
  // preceded by one idle data phase.
  function automatic void model_run();
    exp_q = {};
    exp_q.push_back('{1'b1, 1'b0, 32'h0});
    foreach (seq_q[i]) begin
      xfer_t x = seq_q[i];
      int idx = int'(x.addr) / 4;
      case (kind_of(x))
        1: begin
          exp_q.push_back('{1'b0, 1'b1, 32'h0});
          exp_q.push_back('{1'b1, 1'b1, 32'h0});
        end
        2: begin
          bit [31:0] w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
          for (int b = 0; b < (1 << x.size); b++) begin
            int lane = (int'(x.addr) % 4) + b;
            w[8*lane +: 8] = x.wdata[8*lane +: 8];
          end
          mem_m[idx] = w;
          exp_q.push_back('{1'b1, 1'b0, 32'h0});
        end
        3: begin
          bit [31:0] r = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
          if (wait_en) exp_q.push_back('{1'b0, 1'b0, 32'h0});
          exp_q.push_back('{1'b1, 1'b0, r});
        end
        default: exp_q.push_back('{1'b1, 1'b0, 32'h0});
      endcase
    end
  endfunction

  task automatic drive_addr(xfer_t x);
    bus.HSEL   = x.sel;
    bus.HTRANS = x.trans;
    bus.HWRITE = x.write;
    bus.HSIZE  = x.size;
    bus.HADDR  = x.addr;
    bus.HBURST = 3'($urandom_range(0, 7));
    bus.HPROT  = 4'($urandom_range(0, 15));
  endtask

  // Pipelined master: address phase of item i overlaps the data phase of
  // item i-1; every data-phase cycle is sampled on the falling edge.
  task automatic drive_seq();
    xfer_t prev = '0;
    xfer_t cur;
    logic  rdy;
    obs_q = {};
    for (int i = 0; i <= seq_q.size(); i++) begin
      cur = (i < seq_q.size()) ? seq_q[i] : xfer_t'(0);
      drive_addr(cur);
      bus.HWDATA = prev.wdata;
      for (int k = 0; k < 4; k++) begin
        @(negedge HCLK);
        obs_q.push_back('{bus.HREADYOUT, bus.HRESP, bus.HRDATA});
        rdy = bus.HREADYOUT;
        @(posedge HCLK); #1;
        if (rdy === 1'b1) break;
      end
      prev = cur;
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b1;
    drive_addr('0);
    bus.HWDATA = '0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    n_assert++;
    if (bus.HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b, expected 1", bus.HREADYOUT); end
    n_assert++;
    if (bus.HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b, expected 0", bus.HRESP); end
    n_assert++;
    if (bus.HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h, expected 0", bus.HRDATA); end
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
  endtask

  task automatic test_write_read();
    resp_t last;
    seq_q = {};
    add(1, 2'd2, 1, 3'd2, 16'h0010, 32'hDEADBEEF);
    add(1, 2'd2, 0, 3'd2, 16'h0010, 32'h0);
    model_run();
    drive_seq();
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL wr_rd phase count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wr_rd phase %0d: got %b/%b/%h, expected %b/%b/%h", i, obs_q[i].rdy, obs_q[i].resp, obs_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata); end
    end
    last = obs_q[obs_q.size()-1];
    n_assert++;
    if (last.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd data: got %h, expected deadbeef", last.rdata); end
  endtask

  task automatic test_byte_lanes();
    resp_t last;
    seq_q = {};
    add(1, 2'd2, 1, 3'd2, 16'h0020, 32'h00000000);
    add(1, 2'd3, 1, 3'd0, 16'h0022, 32'h00AA0000);
    add(1, 2'd3, 1, 3'd1, 16'h0020, 32'h00005566);
    add(1, 2'd2, 0, 3'd2, 16'h0020, 32'h0);
    model_run();
    drive_seq();
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL lanes phase count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lanes phase %0d: got %b/%b/%h, expected %b/%b/%h", i, obs_q[i].rdy, obs_q[i].resp, obs_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata); end
    end
    last = obs_q[obs_q.size()-1];
    n_assert++;
    if (last.rdata !== 32'h00AA5566) begin n_fail++; $display("FAIL lanes data: got %h, expected 00aa5566", last.rdata); end
  endtask

  task automatic test_unaligned_error();
    seq_q = {};
    add(1, 2'd2, 1, 3'd2, 16'h0013, 32'hCAFEF00D);
    add(1, 2'd2, 0, 3'd2, 16'h0010, 32'h0);
    model_run();
    drive_seq();
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL unaligned phase count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL unaligned phase %0d: got %b/%b/%h, expected %b/%b/%h", i, obs_q[i].rdy, obs_q[i].resp, obs_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata); end
    end
    n_assert++;
    if (obs_q.size() < 4) begin
      n_fail++; $display("FAIL unaligned short: got %0d phases, expected at least 4", obs_q.size());
    end else if (obs_q[1] !== resp_t'({1'b0, 1'b1, 32'h0}) || obs_q[2] !== resp_t'({1'b1, 1'b1, 32'h0})
                 || obs_q[obs_q.size()-1].rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL unaligned err/data: got %b%b %b%b %h, expected 01 11 deadbeef", obs_q[1].rdy, obs_q[1].resp, obs_q[2].rdy, obs_q[2].resp, obs_q[obs_q.size()-1].rdata);
    end
  endtask

  task automatic test_idle_unselected();
    resp_t last;
    seq_q = {};
    add(1, 2'd2, 1, 3'd2, 16'h0030, 32'h12345678);
    add(1, 2'd0, 1, 3'd2, 16'h0030, 32'hFFFFFFFF);
    add(0, 2'd2, 1, 3'd2, 16'h0030, 32'hFFFFFFFF);
    add(1, 2'd1, 1, 3'd2, 16'h0030, 32'hFFFFFFFF);
    add(1, 2'd2, 0, 3'd2, 16'h0030, 32'h0);
    model_run();
    drive_seq();
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL idle phase count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL idle phase %0d: got %b/%b/%h, expected %b/%b/%h", i, obs_q[i].rdy, obs_q[i].resp, obs_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata); end
    end
    last = obs_q[obs_q.size()-1];
    n_assert++;
    if (last.rdata !== 32'h12345678) begin n_fail++; $display("FAIL idle data: got %h, expected 12345678", last.rdata); end
  endtask

  task automatic test_size_error();
    int n_need;
    seq_q = {};
    add(1, 2'd2, 0, 3'd3, 16'h0000, 32'h0);
    add(1, 2'd2, 0, 3'd2, 16'h0010, 32'h0);
    model_run();
    drive_seq();
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL size_err phase count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL size_err phase %0d: got %b/%b/%h, expected %b/%b/%h", i, obs_q[i].rdy, obs_q[i].resp, obs_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata); end
    end
    n_need = wait_en ? 5 : 4;
    n_assert++;
    if (obs_q.size() < n_need) begin
      n_fail++; $display("FAIL size_err short: got %0d phases, expected %0d", obs_q.size(), n_need);
    end else if (obs_q[1] !== resp_t'({1'b0, 1'b1, 32'h0}) || obs_q[2] !== resp_t'({1'b1, 1'b1, 32'h0})
                 || obs_q[n_need-1] !== resp_t'({1'b1, 1'b0, 32'hDEADBEEF})
                 || (wait_en && obs_q[3] !== resp_t'({1'b0, 1'b0, 32'h0}))) begin
      n_fail++; $display("FAIL size_err seq: got %b%b %b%b %b%b %h, expected 01 11 then read of deadbeef", obs_q[1].rdy, obs_q[1].resp, obs_q[2].rdy, obs_q[2].resp, obs_q[3].rdy, obs_q[3].resp, obs_q[n_need-1].rdata);
    end
  endtask

  task automatic test_back_to_back();
    seq_q = {};
    add(1, 2'd2, 1, 3'd2, 16'h0050, 32'h11112222);
    add(1, 2'd3, 1, 3'd2, 16'h0054, 32'h33334444);
    add(1, 2'd2, 0, 3'd2, 16'h0050, 32'h0);
    add(1, 2'd3, 0, 3'd2, 16'h0054, 32'h0);
    add(1, 2'd2, 1, 3'd2, 16'h0050, 32'h55556666);
    add(1, 2'd3, 0, 3'd2, 16'h0050, 32'h0);
    add(1, 2'd3, 1, 3'd0, 16'h0055, 32'h0000AB00);
    add(1, 2'd3, 0, 3'd1, 16'h0054, 32'h0);
    model_run();
    drive_seq();
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b phase count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b phase %0d: got %b/%b/%h, expected %b/%b/%h", i, obs_q[i].rdy, obs_q[i].resp, obs_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata); end
    end
  endtask

  task automatic test_random();
    seq_q = {};
    for (int w = 0; w < 16; w++) add(1, 2'd2, 1, 3'd2, 16'(16'h0100 + 4*w), $urandom);
    for (int n = 0; n < 120; n++) begin
      bit [2:0] sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      add(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), sz,
          16'(16'h0100 + $urandom_range(0, 63)), $urandom);
    end
    model_run();
    drive_seq();
    n_assert++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random phase count: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_assert++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random phase %0d: got %b/%b/%h, expected %b/%b/%h", i, obs_q[i].rdy, obs_q[i].resp, obs_q[i].rdata, exp_q[i].rdy, exp_q[i].resp, exp_q[i].rdata); end
    end
  endtask

  task automatic test_reset_mid_transfer();
    xfer_t x;
    resp_t last;
    seq_q = {};
    add(1, 2'd2, 1, 3'd2, 16'h0040, 32'h11111111);
    model_run();
    drive_seq();
    // write to 0x40 whose data phase is hit by reset: must not land
    x = '0; x.sel = 1; x.trans = 2'd2; x.write = 1; x.size = 3'd2; x.addr = 16'h0040;
    drive_addr(x);
    @(posedge HCLK); #1;
    drive_addr('0);
    bus.HWDATA = 32'h22222222;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_assert++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_write outputs: got %b/%b/%h, expected 1/0/0", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    // reset during the first ERROR cycle
    x = '0; x.sel = 1; x.trans = 2'd2; x.size = 3'd3;
    drive_addr(x);
    @(posedge HCLK); #1;
    drive_addr('0);
    @(negedge HCLK);
    n_assert++;
    if ({bus.HREADYOUT, bus.HRESP} !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid_err err1: got %b/%b, expected 0/1", bus.HREADYOUT, bus.HRESP);
    end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_assert++;
    if ({bus.HREADYOUT, bus.HRESP, bus.HRDATA} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_err outputs: got %b/%b/%h, expected 1/0/0", bus.HREADYOUT, bus.HRESP, bus.HRDATA);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    seq_q = {};
    add(1, 2'd2, 0, 3'd2, 16'h0040, 32'h0);
    model_run();
    drive_seq();
    last = obs_q[obs_q.size()-1];
    n_assert++;
    if (last.rdata !== 32'h11111111) begin n_fail++; $display("FAIL rst_mid_write memory: got %h, expected 11111111", last.rdata); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_unaligned_error();
    test_idle_unselected();
    test_size_error();
    test_back_to_back();
    test_random();
    test_reset_mid_transfer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
